// File: rtl/csa_mp_seq.sv
// Multi-precision add/subtract sequencer: WORDS x 32-bit operands pushed
// through one 32-bit carry-skip adder, LS word first, carry chained in a register.

module CSA (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        of
);
  logic       carry;
  logic       blk_in;
  logic       rc;
  logic       prop;
  logic       p;
  logic [31:0] s;

  // 4-bit ripple blocks; a block whose bits all propagate passes its carry-in straight through
  always_comb begin
    carry  = cin;
    blk_in = 1'b0;
    rc     = 1'b0;
    prop   = 1'b0;
    p      = 1'b0;
    s      = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      blk_in = carry;
      rc     = carry;
      prop   = 1'b1;
      for (int unsigned j = 0; j < 4; j++) begin
        p              = a[4*k+j] ^ b[4*k+j];
        s[4*k+j]       = p ^ rc;
        rc             = (a[4*k+j] & b[4*k+j]) | (p & rc);
        prop           = prop & p;
      end
      carry = prop ? blk_in : rc;
    end
  end

  assign sum  = s;
  assign cout = carry;
  assign of   = (a[31] == b[31]) && (s[31] != a[31]);
endmodule

module csa_mp_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  of
);
  localparam int W  = 32 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_sr;
  logic [W-1:0]    b_sr;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_next;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [31:0]     add_sum;
  logic            add_cout;
  logic            add_of;
  logic            last;

  // b_sr already holds the effective (possibly inverted) B, so the top-word of is the full-width of
  CSA u_add (
    .a    (a_sr[31:0]),
    .b    (b_sr[31:0]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout),
    .of   (add_of)
  );

  always_comb begin
    acc_next = acc >> 32;
    acc_next[W-1 -: 32] = add_sum;
  end

  assign last = (cnt == CW'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      of    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 32;
          b_sr  <= b_sr >> 32;
          acc   <= acc_next;
          carry <= add_cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= acc_next;
            cout  <= add_cout;
            of    <= add_of;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
